// File: rtl/sc_frogmove_ctrl.sv
// sc_frogmove_ctrl: debounces the frog buttons and issues one-cycle load/shift commands to the position
// shift register, with a cooldown after each move and no moves past the lane limits.
module sc_frogmove_ctrl #(
    parameter int DATAWIDTH = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_CYCLES = 8,
    parameter logic [DATAWIDTH-1:0] START_POS = 8'b00010000,
    parameter logic [DATAWIDTH-1:0] LEFT_LIMIT = 8'b10000000,
    parameter logic [DATAWIDTH-1:0] RIGHT_LIMIT = 8'b00010000
) (
    input  logic                 SC_FROGMOVE_CLOCK_50,
    input  logic                 SC_FROGMOVE_RESET_InHigh,
    input  logic                 SC_FROGMOVE_left_InLow,
    input  logic                 SC_FROGMOVE_right_InLow,
    input  logic                 SC_FROGMOVE_restart_InLow,
    input  logic [DATAWIDTH-1:0] SC_FROGMOVE_position_InBUS,
    output logic                 SC_FROGMOVE_load_OutLow,
    output logic [1:0]           SC_FROGMOVE_shiftselection_Out,
    output logic [DATAWIDTH-1:0] SC_FROGMOVE_data_OutBUS,
    output logic                 SC_FROGMOVE_busy_Out,
    output logic                 SC_FROGMOVE_blocked_Out
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CLW = $clog2(COOLDOWN_CYCLES + 1);

    typedef enum logic [2:0] {INIT, LOAD, IDLE, SHIFT_L, SHIFT_R, COOL} state_t;

    state_t state, nextState;
    logic [2:0] rawBtn, pressEvt;
    logic [CLW-1:0] coolCnt;
    logic restartPending, coolDone, anyRestart, leftEvt, rightEvt, restartEvt;
    logic loadNext, busyNext, blockedNext;
    logic [1:0] selNext;

    assign rawBtn = {SC_FROGMOVE_restart_InLow, SC_FROGMOVE_right_InLow, SC_FROGMOVE_left_InLow};
    assign leftEvt = pressEvt[0];
    assign rightEvt = pressEvt[1];
    assign restartEvt = pressEvt[2];

    // per button: 2-flop synchronizer, stability counter, press pulse on debounced falling level
    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic syncA, syncB, debLevel, evt, flip;
        logic [DBW-1:0] cnt;
        assign flip = (syncB != debLevel) && (cnt == DBW'(DEBOUNCE_CYCLES - 1));
        assign pressEvt[i] = evt;
        always_ff @(posedge SC_FROGMOVE_CLOCK_50 or posedge SC_FROGMOVE_RESET_InHigh) begin
            if (SC_FROGMOVE_RESET_InHigh) begin
                syncA <= 1'b1;
                syncB <= 1'b1;
                debLevel <= 1'b1;
                cnt <= '0;
                evt <= 1'b0;
            end else begin
                syncA <= rawBtn[i];
                syncB <= syncA;
                cnt <= (syncB == debLevel || flip) ? '0 : cnt + 1'b1;
                debLevel <= flip ? syncB : debLevel;
                evt <= flip & ~syncB;
            end
        end
    end

    assign coolDone = coolCnt == CLW'(COOLDOWN_CYCLES - 1);
    assign anyRestart = restartEvt | restartPending;

    always_ff @(posedge SC_FROGMOVE_CLOCK_50 or posedge SC_FROGMOVE_RESET_InHigh) begin
        if (SC_FROGMOVE_RESET_InHigh) begin
            state <= INIT;
            coolCnt <= '0;
            restartPending <= 1'b0;
        end else begin
            state <= nextState;
            coolCnt <= (state == COOL && !coolDone) ? coolCnt + 1'b1 : '0;
            restartPending <= (state == LOAD) ? 1'b0 :
                              (restartEvt && (state == COOL || state == SHIFT_L || state == SHIFT_R)) ? 1'b1 :
                              restartPending;
        end
    end

    always_comb begin
        nextState = INIT;
        case (state)
            INIT:    nextState = LOAD;
            LOAD:    nextState = COOL;
            SHIFT_L: nextState = COOL;
            SHIFT_R: nextState = COOL;
            COOL:    nextState = coolDone ? IDLE : COOL;
            IDLE:    nextState = anyRestart ? LOAD :
                                 (leftEvt && rightEvt) ? IDLE :
                                 (leftEvt && SC_FROGMOVE_position_InBUS != LEFT_LIMIT) ? SHIFT_L :
                                 (rightEvt && SC_FROGMOVE_position_InBUS != RIGHT_LIMIT) ? SHIFT_R :
                                 IDLE;
            default: nextState = INIT;
        endcase
    end

    always_comb begin
        loadNext = state != LOAD;
        selNext = (state == SHIFT_L) ? 2'b01 : (state == SHIFT_R) ? 2'b10 : 2'b00;
        busyNext = state != IDLE;
        blockedNext = state == IDLE && !anyRestart && (leftEvt ^ rightEvt) &&
                      ((leftEvt && SC_FROGMOVE_position_InBUS == LEFT_LIMIT) ||
                       (rightEvt && SC_FROGMOVE_position_InBUS == RIGHT_LIMIT));
    end

    always_ff @(posedge SC_FROGMOVE_CLOCK_50 or posedge SC_FROGMOVE_RESET_InHigh) begin
        if (SC_FROGMOVE_RESET_InHigh) begin
            SC_FROGMOVE_load_OutLow <= 1'b1;
            SC_FROGMOVE_shiftselection_Out <= 2'b00;
            SC_FROGMOVE_busy_Out <= 1'b1;
            SC_FROGMOVE_blocked_Out <= 1'b0;
        end else begin
            SC_FROGMOVE_load_OutLow <= loadNext;
            SC_FROGMOVE_shiftselection_Out <= selNext;
            SC_FROGMOVE_busy_Out <= busyNext;
            SC_FROGMOVE_blocked_Out <= blockedNext;
        end
    end

    assign SC_FROGMOVE_data_OutBUS = START_POS;
endmodule

// File: tb/tb_sc_frogmove_ctrl.sv
// tb_sc_frogmove_ctrl: directed scenario tasks for sc_frogmove_ctrl with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=3.
module tb_sc_frogmove_ctrl;
    logic clk = 1'b0;
    logic rst, leftIn, rightIn, restartIn;
    logic [7:0] pos;
    logic loadOut, busyOut, blockedOut;
    logic [1:0] selOut;
    logic [7:0] dataOut;
    int total = 0;
    int bad = 0;

    localparam logic [7:0] START = 8'b00010000;

    sc_frogmove_ctrl #(
        .DATAWIDTH(8), .DEBOUNCE_CYCLES(4), .COOLDOWN_CYCLES(3),
        .START_POS(8'b00010000), .LEFT_LIMIT(8'b10000000), .RIGHT_LIMIT(8'b00010000)
    ) dut (
        .SC_FROGMOVE_CLOCK_50(clk),
        .SC_FROGMOVE_RESET_InHigh(rst),
        .SC_FROGMOVE_left_InLow(leftIn),
        .SC_FROGMOVE_right_InLow(rightIn),
        .SC_FROGMOVE_restart_InLow(restartIn),
        .SC_FROGMOVE_position_InBUS(pos),
        .SC_FROGMOVE_load_OutLow(loadOut),
        .SC_FROGMOVE_shiftselection_Out(selOut),
        .SC_FROGMOVE_data_OutBUS(dataOut),
        .SC_FROGMOVE_busy_Out(busyOut),
        .SC_FROGMOVE_blocked_Out(blockedOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        leftIn = 1'b1; rightIn = 1'b1; restartIn = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; leftIn = 1'b1; rightIn = 1'b1; restartIn = 1'b1; pos = START;
        tick(); tick();
        total += 5;
        if (loadOut !== 1'b1) begin bad++; $display("FAIL reset_load got=%b want=1", loadOut); end
        if (selOut !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b want=00", selOut); end
        if (dataOut !== START) begin bad++; $display("FAIL reset_data got=%b want=%b", dataOut, START); end
        if (busyOut !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busyOut); end
        if (blockedOut !== 1'b0) begin bad++; $display("FAIL reset_blocked got=%b want=0", blockedOut); end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total += 4;
            if (loadOut !== (i == 2 ? 1'b0 : 1'b1)) begin bad++; $display("FAIL start_load cyc=%0d got=%b want=%b", i, loadOut, i != 2); end
            if (busyOut !== (i <= 5)) begin bad++; $display("FAIL start_busy cyc=%0d got=%b want=%b", i, busyOut, i <= 5); end
            if (selOut !== 2'b00) begin bad++; $display("FAIL start_sel cyc=%0d got=%b want=00", i, selOut); end
            if (dataOut !== START) begin bad++; $display("FAIL start_data cyc=%0d got=%b want=%b", i, dataOut, START); end
        end
        settle();
    endtask

    task automatic test_left();
        pos = 8'b00010000; leftIn = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            total += 3;
            if (selOut !== (i == 8 ? 2'b01 : 2'b00)) begin bad++; $display("FAIL left_sel cyc=%0d got=%b want=%b", i, selOut, i == 8 ? 2'b01 : 2'b00); end
            if (loadOut !== 1'b1) begin bad++; $display("FAIL left_load cyc=%0d got=%b want=1", i, loadOut); end
            if (blockedOut !== 1'b0) begin bad++; $display("FAIL left_blocked cyc=%0d got=%b want=0", i, blockedOut); end
        end
        settle();
    endtask

    task automatic test_blocked();
        pos = 8'b10000000; leftIn = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            total += 4;
            if (blockedOut !== (i == 7)) begin bad++; $display("FAIL lblock_pulse cyc=%0d got=%b want=%b", i, blockedOut, i == 7); end
            if (selOut !== 2'b00) begin bad++; $display("FAIL lblock_sel cyc=%0d got=%b want=00", i, selOut); end
            if (loadOut !== 1'b1) begin bad++; $display("FAIL lblock_load cyc=%0d got=%b want=1", i, loadOut); end
            if (busyOut !== 1'b0) begin bad++; $display("FAIL lblock_busy cyc=%0d got=%b want=0", i, busyOut); end
        end
        settle();
        pos = 8'b00010000; rightIn = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            total += 2;
            if (blockedOut !== (i == 7)) begin bad++; $display("FAIL rblock_pulse cyc=%0d got=%b want=%b", i, blockedOut, i == 7); end
            if (selOut !== 2'b00) begin bad++; $display("FAIL rblock_sel cyc=%0d got=%b want=00", i, selOut); end
        end
        settle();
    endtask

    task automatic test_glitch();
        pos = 8'b00100000; rightIn = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 3) rightIn = 1'b1;
            total += 3;
            if (selOut !== 2'b00) begin bad++; $display("FAIL glitch_sel cyc=%0d got=%b want=00", i, selOut); end
            if (loadOut !== 1'b1) begin bad++; $display("FAIL glitch_load cyc=%0d got=%b want=1", i, loadOut); end
            if (blockedOut !== 1'b0) begin bad++; $display("FAIL glitch_blocked cyc=%0d got=%b want=0", i, blockedOut); end
        end
        rightIn = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 6) rightIn = 1'b1;
            total++;
            if (selOut !== (i == 8 ? 2'b10 : 2'b00)) begin bad++; $display("FAIL right_sel cyc=%0d got=%b want=%b", i, selOut, i == 8 ? 2'b10 : 2'b00); end
        end
        settle();
    endtask

    task automatic test_both();
        pos = 8'b00100000; leftIn = 1'b0; rightIn = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            total += 3;
            if (selOut !== 2'b00) begin bad++; $display("FAIL both_sel cyc=%0d got=%b want=00", i, selOut); end
            if (blockedOut !== 1'b0) begin bad++; $display("FAIL both_blocked cyc=%0d got=%b want=0", i, blockedOut); end
            if (busyOut !== 1'b0) begin bad++; $display("FAIL both_busy cyc=%0d got=%b want=0", i, busyOut); end
        end
        settle();
    endtask

    task automatic test_restart();
        pos = 8'b00010000; leftIn = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 3) begin restartIn = 1'b0; rightIn = 1'b0; end
            total += 3;
            if (selOut !== (i == 8 ? 2'b01 : 2'b00)) begin bad++; $display("FAIL rst_req_sel cyc=%0d got=%b want=%b", i, selOut, i == 8 ? 2'b01 : 2'b00); end
            if (loadOut !== (i == 13 ? 1'b0 : 1'b1)) begin bad++; $display("FAIL rst_req_load cyc=%0d got=%b want=%b", i, loadOut, i != 13); end
            if (blockedOut !== 1'b0) begin bad++; $display("FAIL rst_req_blocked cyc=%0d got=%b want=0", i, blockedOut); end
        end
        settle();
    endtask

    task automatic test_midreset();
        pos = 8'b00100000; leftIn = 1'b0;
        repeat (8) tick();
        total++;
        if (selOut !== 2'b01) begin bad++; $display("FAIL mid_shift got=%b want=01", selOut); end
        rst = 1'b1;
        #1;
        total += 3;
        if (selOut !== 2'b00) begin bad++; $display("FAIL mid_async_sel got=%b want=00", selOut); end
        if (loadOut !== 1'b1) begin bad++; $display("FAIL mid_async_load got=%b want=1", loadOut); end
        if (busyOut !== 1'b1) begin bad++; $display("FAIL mid_async_busy got=%b want=1", busyOut); end
        leftIn = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total += 2;
            if (loadOut !== (i == 2 ? 1'b0 : 1'b1)) begin bad++; $display("FAIL mid_reload cyc=%0d got=%b want=%b", i, loadOut, i != 2); end
            if (selOut !== 2'b00) begin bad++; $display("FAIL mid_reload_sel cyc=%0d got=%b want=00", i, selOut); end
        end
        total++;
        if (dataOut !== START) begin bad++; $display("FAIL mid_data got=%b want=%b", dataOut, START); end
    endtask

    initial begin
        test_reset();
        test_left();
        test_blocked();
        test_glitch();
        test_both();
        test_restart();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
